// File: rtl/add_16_pipe_ctrl_if.sv
// Signal bundle between the adder issue/capture controller and its environment
// (producer, consumer and the external pipelined adder).
interface add_16_pipe_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_chain;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  // Controller side.
  modport master (
    input  in_valid, in_a, in_b, in_cin, in_chain, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );

  // Producer, consumer and adder side.
  modport slave (
    output in_valid, in_a, in_b, in_cin, in_chain, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/add_16_pipe_ctrl.sv
// Issue/capture controller around a fixed-latency pipelined adder: registered
// operand issue, valid tracking through the adder, credit-guarded result FIFO.
module add_16_pipe_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADD_LAT = 3,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clock,
  input  logic               reset_b,
  add_16_pipe_ctrl_if.master bus
);
  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   OW      = AW + 2;
  localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

  logic [ADD_LAT:0] r_vp;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_cin;
  logic             r_last_cout;
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;

  logic [OW-1:0]    w_inflight;
  logic [OW-1:0]    w_occ;
  logic             w_in_ready;
  logic             w_acc;
  logic             w_cap;
  logic             w_pop;
  logic [WIDTH:0]   w_head;

  always_comb begin
    w_inflight = '0;
    for (int unsigned k = 0; k <= ADD_LAT; k++) begin
      w_inflight = w_inflight + OW'(r_vp[k]);
    end
  end

  // Every issued op holds a credit until popped, so capture never overflows;
  // a chained op must see the final carry of everything issued before it.
  assign w_occ      = w_inflight + OW'(r_cnt);
  assign w_in_ready = (w_occ < DEPTH_W) && !(bus.in_chain && (w_inflight != '0));
  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_cap      = r_vp[ADD_LAT];
  assign w_pop      = (r_cnt != '0) && bus.out_ready;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_vp        <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
      r_last_cout <= 1'b0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
    end else begin
      r_vp <= {r_vp[ADD_LAT-1:0], w_acc};
      if (w_acc) begin
        r_add_a   <= bus.in_a;
        r_add_b   <= bus.in_b;
        r_add_cin <= bus.in_chain ? r_last_cout : bus.in_cin;
      end
      if (w_cap) begin
        r_last_cout <= bus.add_cout;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      unique case ({w_cap, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_cap) begin
      r_mem[r_wr] <= {bus.add_cout, bus.add_sum};
    end
  end

  assign w_head        = r_mem[r_rd];
  assign bus.in_ready  = w_in_ready;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.add_cin   = r_add_cin;
  assign bus.out_valid = (r_cnt != '0);
  assign bus.out_sum   = w_head[WIDTH-1:0];
  assign bus.out_cout  = w_head[WIDTH];
endmodule

// File: tb/tb_add_16_pipe_ctrl.sv
// Self-checking bench: random traffic against a queue-based reference of
// issue-ordered a+b+cin results, with a 3-stage adder stand-in.
module tb_add_16_pipe_ctrl;
  logic clock;
  logic reset_b;

  add_16_pipe_ctrl_if #(.WIDTH(16)) bus ();

  add_16_pipe_ctrl #(.WIDTH(16), .ADD_LAT(3), .DEPTH(8)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External adder stand-in: input register, compute register, output register.
  logic [15:0] ad_ir_a, ad_ir_b;
  logic        ad_ir_c;
  logic [16:0] ad_pr, ad_or;
  always @(posedge clock) begin
    ad_ir_a <= bus.add_a;
    ad_ir_b <= bus.add_b;
    ad_ir_c <= bus.add_cin;
    ad_pr   <= {1'b0, ad_ir_a} + {1'b0, ad_ir_b} + {16'b0, ad_ir_c};
    ad_or   <= ad_pr;
  end
  assign bus.add_sum  = ad_or[15:0];
  assign bus.add_cout = ad_or[16];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_acc   = 0;
  int unsigned n_out   = 0;
  int unsigned cyc     = 0;
  int unsigned acc_cyc = 0;
  logic [16:0] exp_q[$];
  logic        m_last_cout = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock: settle, score handshakes that will fire at the next edge, advance.
  task automatic step();
    logic [16:0] e;
    logic        c;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_sum", {16'b0, bus.out_sum}, {16'b0, e[15:0]});
        check("out_cout", {31'b0, bus.out_cout}, {31'b0, e[16]});
        n_out++;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      c = bus.in_chain ? m_last_cout : bus.in_cin;
      e = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {16'b0, c};
      exp_q.push_back(e);
      m_last_cout = e[16];
      n_acc++;
      acc_cyc = cyc;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic chain);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_chain = chain;
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget && exp_q.size() != 0; i++) step();
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    int unsigned a0, o0, c0;
    reset_b = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #23;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_add_a", {16'b0, bus.add_a}, 32'd0);
    check("rst_add_b", {16'b0, bus.add_b}, 32'd0);
    check("rst_add_cin", {31'b0, bus.add_cin}, 32'd0);
    @(negedge clock);
    reset_b = 1'b1;
    @(negedge clock);

    // Basic latency: visible after the 4th edge following the accept.
    drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int unsigned k = 1; k <= 4; k++) begin
      step();
      check($sformatf("lat_valid_%0d", k), {31'b0, bus.out_valid}, {31'b0, k == 4});
    end
    check("basic_sum_head", {16'b0, bus.out_sum}, 32'h5555);
    bus.out_ready = 1'b1;
    drain("basic_drain", 4);

    // Carry out then a chained op that must wait for it.
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    step();
    c0 = acc_cyc;
    a0 = n_acc;
    drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 20 && n_acc == a0; i++) step();
    check("chain_accepted", n_acc - a0, 32'd1);
    check("chain_gap", acc_cyc - c0, 32'd5);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drain("chain_drain", 20);

    // Throughput: 20 back-to-back, one result per cycle.
    a0 = n_acc; o0 = n_out;
    for (int unsigned i = 0; i < 20; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      step();
    end
    check("tp_accepts", n_acc - a0, 32'd20);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) step();
    check("tp_results", n_out - o0, 32'd20);

    // Backpressure: exactly DEPTH credits.
    bus.out_ready = 1'b0;
    a0 = n_acc; o0 = n_out;
    for (int unsigned i = 0; i < 20; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      step();
    end
    check("bp_accepts", n_acc - a0, 32'd8);
    #1;
    check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) step();
    check("bp_drained", n_out - o0, 32'd8);
    check("bp_empty", {31'b0, bus.out_valid}, 32'd0);

    // Asynchronous reset mid-flight.
    bus.out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 2; i++) step();
    check("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    reset_b = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    exp_q.delete();
    m_last_cout = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_b = 1'b1;
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) step();
    check("post_rst_idle", {31'b0, bus.out_valid}, 32'd0);
    drive(1'b1, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drain("post_rst_drain", 10);

    // Random mixed traffic with chaining and backpressure.
    for (int unsigned i = 0; i < 400; i++) begin
      drive(1'($urandom_range(3) != 0), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom_range(3) == 0));
      bus.out_ready = 1'($urandom_range(2) != 0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    drain("rand_drain", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/add_16_pipe_ctrl.md
Name: add_16_pipe_ctrl

Overview:
Issue and capture controller wrapped around the 16-bit pipelined adder. The adder has no valid, stall or reset of its own.
- Upstream: accepts operand pairs over valid/ready and drives the adder's a/b/c_in ports from registers.
- Latency tracking: follows each issued operation through the adder's fixed latency with a valid shift register.
- Downstream: captures {c_out,sum} into a result FIFO drained over valid/ready.
- Credit rule: occupancy credits guarantee no result is ever dropped, even though the adder cannot stall.
- Chaining: optional carry chaining lets consecutive words form wider additions.

Parameters:
WIDTH, 16, operand/sum width; must equal the adder's size.
ADD_LAT, 3, adder latency in clock edges from operand sampling to valid output register (IR, PR, OR).
DEPTH, 8, result FIFO depth and total credit limit; power of two, and DEPTH >= ADD_LAT+3 for one result per cycle.

Ports:
clock  input  1  rising-edge clock, shared with the adder.
reset_b  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair offered.
in_ready  output  1  controller accepts on in_valid&&in_ready at a rising edge.
in_a  input  WIDTH  operand a.
in_b  input  WIDTH  operand b.
in_cin  input  1  carry-in, used when in_chain=0.
in_chain  input  1  1: use carry-out of the most recently completed result as carry-in.
add_a  output  WIDTH  to adder a.
add_b  output  WIDTH  to adder b.
add_cin  output  1  to adder c_in.
add_sum  input  WIDTH  from adder sum.
add_cout  input  1  from adder c_out.
out_valid  output  1  result available at FIFO head.
out_ready  input  1  consumer takes the result on out_valid&&out_ready.
out_sum  output  WIDTH  head result sum.
out_cout  output  1  head result carry-out.

Behaviour:
- Reset (async, reset_b=0):
  - add_a, add_b, add_cin = 0; valid pipe vp[ADD_LAT:0] = 0.
  - FIFO pointers and count = 0; last_cout = 0.
  - Therefore in_ready = 1 and out_valid = 0.
  - Adder internal contents are garbage after reset. They are ignored because vp is cleared.
  - Reset mid-operation discards all in-flight and queued results.
- Accept at edge N:
  - add_a <= in_a, add_b <= in_b.
  - add_cin <= in_chain ? last_cout : in_cin.
  - vp[0] <= 1. Otherwise vp[0] <= 0 and add_* hold their values.
- Each edge: vp[k] <= vp[k-1] for k=1..ADD_LAT.
  - vp[ADD_LAT]=1 means the adder output register holds that operation's result.
- Capture: at the edge where vp[ADD_LAT]=1:
  - {add_cout, add_sum} is written to the FIFO tail;
  - last_cout <= add_cout.
  - With the FIFO empty, out_valid rises after edge N+ADD_LAT+1 (N+4 by default).
- Ordering: results leave in issue order. No reordering, no bubbles inserted.
- Credits:
  - inflight = popcount(vp); occ = inflight + fifo_count. Both are derived from registers.
  - in_ready = (occ < DEPTH) && !(in_chain && inflight != 0).
  - in_ready may depend combinationally on in_chain; no other input-to-output combinational paths.
  - Because of this rule the FIFO can never overflow at capture.
- Chaining:
  - A chained op waits until every earlier op has completed. last_cout is then final.
  - Chained throughput is one op per ADD_LAT+2 cycles.
- FIFO:
  - out_sum and out_cout reflect the head entry; out_valid = (fifo_count != 0).
  - Simultaneous capture and pop: count unchanged, both pointers advance. This covers the full and the single-entry cases.
  - Pop when empty is impossible because out_valid = 0.
  - Head data must be held stable while out_valid=1 && out_ready=0.
- Arithmetic is done entirely by the adder. The controller never modifies sum or carry; wrap-around is reported through out_cout.

Test Plan:
- Basic: reset, then accept a=16'h1234, b=16'h4321, cin=0 at edge N -> out_valid rises after edge N+4 with out_sum=16'h5555, out_cout=0.
- Carry and chain:
  - Issue FFFF+0001 cin=0 -> out_sum=0000, cout=1.
  - Then chained 0000+0000 -> in_ready low until the first result is captured; second result out_sum=0001, cout=0.
- Throughput: out_ready=1 held, 20 back-to-back random ops -> in_ready never drops; 20 results in order, one per cycle, matching a+b+cin.
- Backpressure:
  - out_ready=0 and in_valid=1 -> exactly DEPTH=8 accepts, then in_ready=0, and the FIFO holds 8 results.
  - Then raise out_ready -> all 8 are drained in order and no result is lost.
- Reset mid-flight: issue 3 ops, then assert reset_b=0 asynchronously between edges -> out_valid=0 immediately and in_ready=1. After release no stale results appear and the next op returns correctly.
